// File: rtl/btb_update_queue_if.sv
// Handshake and BTB write-port bundle for btb_update_queue.
// master: backend + BTB side; slave: the queue.
interface btb_update_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              res_valid_i;
  logic              res_ready_o;
  logic [31:2]       res_pc_i;
  logic              res_taken_i;
  logic [31:2]       res_target_i;
  logic [1:0]        res_br_type_i;
  logic [31:2]       res_pred_bta_i;
  logic [1:0]        res_pred_br_type_i;
  logic              upd_ready_i;
  logic              update_o;
  logic [31:2]       wpc_o;
  logic [31:2]       bta_o;
  logic [1:0]        br_type_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output res_valid_i, res_pc_i, res_taken_i, res_target_i, res_br_type_i,
           res_pred_bta_i, res_pred_br_type_i, upd_ready_i,
    input  res_ready_o, update_o, wpc_o, bta_o, br_type_o, count_o
  );

  modport slave (
    input  res_valid_i, res_pc_i, res_taken_i, res_target_i, res_br_type_i,
           res_pred_bta_i, res_pred_br_type_i, upd_ready_i,
    output res_ready_o, update_o, wpc_o, bta_o, br_type_o, count_o
  );
endinterface

// File: rtl/btb_update_queue.sv
// btb_update_queue: filters resolved branches down to BTB writes, coalesces
// writes to the same PC in a small circular FIFO, drains one write per cycle.
// Optional BTB_UPDQ_PERF_EN adds saturating 32-bit perf counters.
module btb_update_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  btb_update_queue_if.slave    bus
`ifdef BTB_UPDQ_PERF_EN
  ,
  output logic [31:0]          perf_resolved_o,
  output logic [31:0]          perf_update_o,
  output logic [31:0]          perf_coalesce_o
`endif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:2] bta;
    logic [1:0]  br_type;
  } entry_t;

  entry_t             entry_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;

  logic               need_upd;
  logic               accept;
  logic               wr_upd;
  logic               pop;
  logic               hit;
  logic [PTR_W-1:0]   hit_idx;
  logic               push;
  logic               coalesce;

  assign bus.res_ready_o = (count_q != CNT_W'(DEPTH));
  assign bus.update_o    = (count_q != '0);
  assign bus.count_o     = count_q;
  assign bus.wpc_o       = bus.update_o ? entry_q[head_q].pc      : '0;
  assign bus.bta_o       = bus.update_o ? entry_q[head_q].bta     : '0;
  assign bus.br_type_o   = bus.update_o ? entry_q[head_q].br_type : '0;

  assign need_upd = bus.res_taken_i &
                    ((bus.res_target_i != bus.res_pred_bta_i) |
                     (bus.res_br_type_i != bus.res_pred_br_type_i));
  assign accept   = bus.res_valid_i & bus.res_ready_o;
  assign wr_upd   = accept & need_upd;
  assign pop      = bus.update_o & bus.upd_ready_i;
  assign push     = wr_upd & ~hit;
  assign coalesce = wr_upd & hit;

  // Find a live entry with the same PC; the head leaving this cycle is excluded
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].pc == bus.res_pc_i) &&
          !(pop && (head_q == PTR_W'(i)))) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[tail_q]         <= 1'b1;
        entry_q[tail_q].pc      <= bus.res_pc_i;
        entry_q[tail_q].bta     <= bus.res_target_i;
        entry_q[tail_q].br_type <= bus.res_br_type_i;
        tail_q                  <= tail_q + PTR_W'(1);
      end
      if (coalesce) begin
        entry_q[hit_idx].bta     <= bus.res_target_i;
        entry_q[hit_idx].br_type <= bus.res_br_type_i;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef BTB_UPDQ_PERF_EN
  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_resolved_o <= '0;
      perf_update_o   <= '0;
      perf_coalesce_o <= '0;
    end else begin
      if (accept && (perf_resolved_o != 32'hFFFF_FFFF)) begin
        perf_resolved_o <= perf_resolved_o + 32'd1;
      end
      if (pop && (perf_update_o != 32'hFFFF_FFFF)) begin
        perf_update_o <= perf_update_o + 32'd1;
      end
      if (coalesce && (perf_coalesce_o != 32'hFFFF_FFFF)) begin
        perf_coalesce_o <= perf_coalesce_o + 32'd1;
      end
    end
  end
`endif

endmodule
